// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin controller for a small bank of storage registers.
// Each access runs IDLE -> XFER -> DONE; the whole bank is exported flat.
module reg_bank_arbiter #(
    parameter int unsigned NREG = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        wdata0,
    input  logic [DW-1:0]        wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic [DW-1:0]        rdata,
    output logic [NREG*DW-1:0]   bank
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    state_t                     state, state_n;
    cmd_t                       cmd, cmd_n;
    logic                       last, last_n;
    logic                       win;
    logic [1:0]                 gnt_n;
    logic                       ack0_n, ack1_n, busy_n;
    logic [DW-1:0]              rdata_n;
    logic [NREG-1:0][DW-1:0]    regs, regs_n;

    assign bank = regs;

    // Next-state, command latch and bank access
    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        last_n  = last;
        gnt_n   = gnt;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        rdata_n = rdata;
        regs_n  = regs;
        win     = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie, the requester that was not served last wins
                    win         = (req0 && req1) ? ~last : req1;
                    cmd_n.id    = win;
                    cmd_n.we    = win ? we1 : we0;
                    cmd_n.addr  = win ? addr1 : addr0;
                    cmd_n.wdata = win ? wdata1 : wdata0;
                    gnt_n       = win ? 2'b10 : 2'b01;
                    state_n     = XFER;
                end
            end
            XFER: begin
                if (cmd.we) begin
                    regs_n[cmd.addr] = cmd.wdata;
                end else begin
                    rdata_n = regs[cmd.addr];
                end
                ack0_n  = ~cmd.id;
                ack1_n  = cmd.id;
                last_n  = cmd.id;
                state_n = DONE;
            end
            DONE: begin
                gnt_n   = 2'b00;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = 2'b00;
                state_n = IDLE;
            end
        endcase

        // Clear overrides any write landing on the same edge
        if (clr) begin
            regs_n = '0;
        end

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cmd   <= '0;
            last  <= 1'b1;
            gnt   <= 2'b00;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            busy  <= 1'b0;
            rdata <= '0;
            regs  <= '0;
        end else begin
            state <= state_n;
            cmd   <= cmd_n;
            last  <= last_n;
            gnt   <= gnt_n;
            ack0  <= ack0_n;
            ack1  <= ack1_n;
            busy  <= busy_n;
            rdata <= rdata_n;
            regs  <= regs_n;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for command latching and asynchronous reset.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        req0, req1;
    logic        we0, we1;
    logic [1:0]  addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1;
    logic [1:0]  gnt;
    logic        busy;
    logic [7:0]  rdata;
    logic [31:0] bank;

    int checks;
    int errors;

    reg_bank_arbiter #(.NREG(4), .DW(8), .AW(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .gnt    (gnt),
        .busy   (busy),
        .rdata  (rdata),
        .bank   (bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req0;
        logic        we0;
        logic [1:0]  addr0;
        logic [7:0]  wd0;
        logic        req1;
        logic        we1;
        logic [1:0]  addr1;
        logic [7:0]  wd1;
        logic        clr;
        logic [1:0]  gnt;
        logic        ack0;
        logic        ack1;
        logic        busy;
        logic        chk_rd;
        logic [7:0]  rd;
        logic [31:0] bank;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = 2'd0; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 2'd0; wdata1 = 8'h00;
        clr  = 1'b0;
    endtask

    initial begin
        logic saw_ack;
        checks = 0;
        errors = 0;

        // req0 we0 a0 wd0 | req1 we1 a1 wd1 | clr | gnt ack0 ack1 busy | chk rd | bank
        // single write then read-back
        vq.push_back('{1'b1,1'b1,2'd2,8'hA5, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b01,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h0000_0000});
        vq.push_back('{1'b1,1'b1,2'd2,8'hA5, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b01,1'b1,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b0,8'h00, 32'h00A5_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd2,8'h00, 1'b0, 2'b10,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd2,8'h00, 1'b0, 2'b10,1'b0,1'b1,1'b1, 1'b1,8'hA5, 32'h00A5_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b1,8'hA5, 32'h00A5_0000});
        // contention: grants alternate 0,1,0
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b1,1'b1,2'd1,8'h22, 1'b0, 2'b01,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_0000});
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b1,1'b1,2'd1,8'h22, 1'b0, 2'b01,1'b1,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_0011});
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b1,1'b1,2'd1,8'h22, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b0,8'h00, 32'h00A5_0011});
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b1,1'b1,2'd1,8'h22, 1'b0, 2'b10,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_0011});
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b1,1'b1,2'd1,8'h22, 1'b0, 2'b10,1'b0,1'b1,1'b1, 1'b0,8'h00, 32'h00A5_2211});
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b0,8'h00, 32'h00A5_2211});
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b01,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_2211});
        vq.push_back('{1'b1,1'b1,2'd0,8'h11, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b01,1'b1,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_2211});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b0,8'h00, 32'h00A5_2211});
        // clr on the XFER edge of a write: write lost, ack still issued
        vq.push_back('{1'b1,1'b1,2'd3,8'h5A, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b01,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h00A5_2211});
        vq.push_back('{1'b1,1'b1,2'd3,8'h5A, 1'b0,1'b0,2'd0,8'h00, 1'b1, 2'b01,1'b1,1'b0,1'b1, 1'b0,8'h00, 32'h0000_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b0,8'h00, 32'h0000_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd3,8'h00, 1'b0, 2'b10,1'b0,1'b0,1'b1, 1'b1,8'hA5, 32'h0000_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd3,8'h00, 1'b0, 2'b10,1'b0,1'b1,1'b1, 1'b1,8'h00, 32'h0000_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b1,8'h00, 32'h0000_0000});
        // read coinciding with clr returns the pre-clear value
        vq.push_back('{1'b1,1'b1,2'd1,8'h77, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b01,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h0000_0000});
        vq.push_back('{1'b1,1'b1,2'd1,8'h77, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b01,1'b1,1'b0,1'b1, 1'b0,8'h00, 32'h0000_7700});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b0,8'h00, 32'h0000_7700});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'h00, 1'b0, 2'b10,1'b0,1'b0,1'b1, 1'b0,8'h00, 32'h0000_7700});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'h00, 1'b1, 2'b10,1'b0,1'b1,1'b1, 1'b1,8'h77, 32'h0000_0000});
        vq.push_back('{1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0, 1'b1,8'h77, 32'h0000_0000});

        // reset and check reset state before any active edge
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("reset gnt",   32'(gnt),   32'd0);
        check("reset ack",   32'({ack1, ack0}), 32'd0);
        check("reset busy",  32'(busy),  32'd0);
        check("reset rdata", 32'(rdata), 32'd0);
        check("reset bank",  bank,       32'd0);

        foreach (vq[i]) begin
            req0 = vq[i].req0; we0 = vq[i].we0; addr0 = vq[i].addr0; wdata0 = vq[i].wd0;
            req1 = vq[i].req1; we1 = vq[i].we1; addr1 = vq[i].addr1; wdata1 = vq[i].wd1;
            clr  = vq[i].clr;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d gnt", i),  32'(gnt),  32'(vq[i].gnt));
            check($sformatf("row%0d ack0", i), 32'(ack0), 32'(vq[i].ack0));
            check($sformatf("row%0d ack1", i), 32'(ack1), 32'(vq[i].ack1));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vq[i].busy));
            check($sformatf("row%0d bank", i), bank,      vq[i].bank);
            if (vq[i].chk_rd) begin
                check($sformatf("row%0d rdata", i), 32'(rdata), 32'(vq[i].rd));
            end
        end

        // command latch: wdata changes after grant are ignored
        idle_inputs();
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h33;
        @(posedge clk);
        @(negedge clk);
        check("latch gnt", 32'(gnt), 32'd1);
        wdata0 = 8'hCC;
        @(posedge clk);
        @(negedge clk);
        check("latch ack0", 32'(ack0), 32'd1);
        check("latch bank", bank, 32'h0000_0033);
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("latch idle busy", 32'(busy), 32'd0);
        check("latch bank hold", bank, 32'h0000_0033);

        // asynchronous reset between grant and XFER edges aborts the write
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd2; wdata1 = 8'h99;
        @(posedge clk);
        #2;
        check("abort gnt pre", 32'(gnt), 32'd2);
        check("abort busy pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort gnt",   32'(gnt), 32'd0);
        check("abort busy",  32'(busy), 32'd0);
        check("abort ack",   32'({ack1, ack0}), 32'd0);
        check("abort bank",  bank, 32'd0);
        check("abort rdata", 32'(rdata), 32'd0);
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        saw_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            saw_ack = saw_ack | ack1 | ack0;
        end
        check("abort no ack", 32'(saw_ack), 32'd0);
        check("abort bank after", bank, 32'd0);
        check("abort gnt after", 32'(gnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
